// File: rtl/mlp_seq_pkg.sv
// Shared types and layout helpers for the time-multiplexed MLP classifier.
// Offsets locate one weight or bias inside the flat, LSB-first parameter buses.
package mlp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L0   = 2'd1,
    L1   = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cls_width(input int n_out);
    return idx_width(n_out);
  endfunction

  function automatic int w0_off(input int n, input int k, input int n_in, input int w_w);
    return (n * n_in + k) * w_w;
  endfunction

  function automatic int w1_off(input int m, input int j, input int n_in, input int n_hid,
                                input int w_w);
    return (n_hid * n_in + m * n_hid + j) * w_w;
  endfunction

  function automatic int b0_off(input int n, input int b0_w);
    return n * b0_w;
  endfunction

  function automatic int b1_off(input int m, input int n_hid, input int b0_w, input int b1_w);
    return n_hid * b0_w + m * b1_w;
  endfunction

endpackage

// File: rtl/mlp_seq_engine_if.sv
// Input-vector and result handshakes of the MLP engine.
// master = producer/consumer side, slave = engine side.
interface mlp_seq_engine_if
  import mlp_seq_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int IN_W  = 4,
  parameter int N_OUT = 3,
  parameter int ACC_W = 32
) ();
  localparam int CLS_W = cls_width(N_OUT);

  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*IN_W-1:0]   inp;
  logic                   out_valid;
  logic                   out_ready;
  logic [CLS_W-1:0]       out;
  logic [ACC_W-2:0]       out_score;

  modport master (output in_valid, inp, out_ready,
                  input  in_ready, out_valid, out, out_score);
  modport slave  (input  in_valid, inp, out_ready,
                  output in_ready, out_valid, out, out_score);
endinterface

// File: rtl/mlp_mac_unit.sv
// Signed multiply-accumulate: a signed weight times a zero-extended activation.
// load replaces the accumulator with a bias; acc_next exposes the value about to be stored.
module mlp_mac_unit #(
  parameter int W_W   = 8,
  parameter int X_W   = 31,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [ACC_W-1:0] bias,
  input  logic [W_W-1:0]   w,
  input  logic [X_W-1:0]   x,
  output logic [ACC_W-1:0] acc_next
);
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] prod;
  logic        [ACC_W-1:0] acc_q;
  logic        [ACC_W-1:0] acc_d;

  assign w_ext = {{(ACC_W-W_W){w[W_W-1]}}, w};
  assign x_ext = {{(ACC_W-X_W){1'b0}}, x};
  assign prod  = w_ext * x_ext;

  always_comb begin
    if (load) begin
      acc_d = bias;
    end else if (en) begin
      acc_d = acc_q + prod;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next = acc_d;
endmodule

// File: rtl/mlp_seq_engine.sv
// Sequential two-layer ReLU MLP with argmax, one shared MAC product per cycle.
// Each neuron spends one bias-load cycle followed by one cycle per fan-in term.
module mlp_seq_engine
  import mlp_seq_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int IN_W  = 4,
  parameter int N_HID = 3,
  parameter int N_OUT = 3,
  parameter int W_W   = 8,
  parameter int B0_W  = 11,
  parameter int B1_W  = 14,
  parameter int ACC_W = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  mlp_seq_engine_if.slave                        io,
  input  logic [(N_HID*N_IN+N_OUT*N_HID)*W_W-1:0] weights,
  input  logic [N_HID*B0_W+N_OUT*B1_W-1:0]       biases
);
  localparam int CLS_W   = cls_width(N_OUT);
  localparam int S_W     = ACC_W - 1;
  localparam int MAX_FAN = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int MAX_NRN = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int K_W     = idx_width(MAX_FAN + 1);
  localparam int N_W     = idx_width(MAX_NRN);

  if (ACC_W < W_W + (W_W + IN_W + 1) + $clog2(MAX_FAN + 1) + 1) begin : g_acc_too_narrow
    $error("mlp_seq_engine: ACC_W too narrow for the configured topology");
  end
  if (N_OUT < 2) begin : g_too_few_classes
    $error("mlp_seq_engine: N_OUT must be at least 2");
  end

  state_e                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [N_IN*IN_W-1:0]  inp_q, inp_d;
  logic [S_W-1:0]        hid_q [N_HID];
  logic [S_W-1:0]        hid_d [N_HID];
  logic [CLS_W-1:0]      out_q, out_d;
  logic [S_W-1:0]        score_q, score_d;
  logic                  in_ready_q, out_valid_q;

  logic                  mac_load, mac_en;
  logic [ACC_W-1:0]      mac_bias, acc_next;
  logic [W_W-1:0]        mac_w, w0_sel, w1_sel;
  logic [S_W-1:0]        mac_x, x1_sel, relu_s;
  logic [IN_W-1:0]       x0_sel;
  logic [B0_W-1:0]       b0_sel;
  logic [B1_W-1:0]       b1_sel;

  mlp_mac_unit #(.W_W(W_W), .X_W(S_W), .ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .load     (mac_load),
    .en       (mac_en),
    .bias     (mac_bias),
    .w        (mac_w),
    .x        (mac_x),
    .acc_next (acc_next)
  );

  assign relu_s = acc_next[ACC_W-1] ? {S_W{1'b0}} : acc_next[S_W-1:0];

  // Step k selects term k-1 of the current neuron; step 0 is the bias cycle.
  always_comb begin
    w0_sel = {W_W{1'b0}};
    w1_sel = {W_W{1'b0}};
    b0_sel = {B0_W{1'b0}};
    b1_sel = {B1_W{1'b0}};
    x0_sel = {IN_W{1'b0}};
    x1_sel = {S_W{1'b0}};
    for (int n = 0; n < N_HID; n++) begin
      b0_sel = (n_q == N_W'(n)) ? biases[b0_off(n, B0_W) +: B0_W] : b0_sel;
      for (int k = 0; k < N_IN; k++) begin
        w0_sel = (n_q == N_W'(n) && k_q == K_W'(k + 1)) ?
                 weights[w0_off(n, k, N_IN, W_W) +: W_W] : w0_sel;
      end
    end
    for (int m = 0; m < N_OUT; m++) begin
      b1_sel = (n_q == N_W'(m)) ? biases[b1_off(m, N_HID, B0_W, B1_W) +: B1_W] : b1_sel;
      for (int j = 0; j < N_HID; j++) begin
        w1_sel = (n_q == N_W'(m) && k_q == K_W'(j + 1)) ?
                 weights[w1_off(m, j, N_IN, N_HID, W_W) +: W_W] : w1_sel;
      end
    end
    for (int k = 0; k < N_IN; k++) begin
      x0_sel = (k_q == K_W'(k + 1)) ? inp_q[k*IN_W +: IN_W] : x0_sel;
    end
    for (int j = 0; j < N_HID; j++) begin
      x1_sel = (k_q == K_W'(j + 1)) ? hid_q[j] : x1_sel;
    end
  end

  // Sequencing, hidden-layer writeback and running argmax.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    inp_d    = inp_q;
    hid_d    = hid_q;
    out_d    = out_q;
    score_d  = score_q;
    mac_load = 1'b0;
    mac_en   = 1'b0;
    mac_bias = {ACC_W{1'b0}};
    mac_w    = {W_W{1'b0}};
    mac_x    = {S_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          inp_d   = io.inp;
          n_d     = {N_W{1'b0}};
          k_d     = {K_W{1'b0}};
          state_d = L0;
        end else begin
          state_d = IDLE;
        end
      end
      L0: begin
        mac_load = (k_q == {K_W{1'b0}});
        mac_en   = !mac_load;
        mac_bias = {{(ACC_W-B0_W){b0_sel[B0_W-1]}}, b0_sel};
        mac_w    = w0_sel;
        mac_x    = {{(S_W-IN_W){1'b0}}, x0_sel};
        if (k_q == K_W'(N_IN)) begin
          for (int n = 0; n < N_HID; n++) begin
            hid_d[n] = (n_q == N_W'(n)) ? relu_s : hid_q[n];
          end
          k_d = {K_W{1'b0}};
          if (n_q == N_W'(N_HID - 1)) begin
            n_d     = {N_W{1'b0}};
            state_d = L1;
          end else begin
            n_d = n_q + N_W'(1);
          end
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      L1: begin
        mac_load = (k_q == {K_W{1'b0}});
        mac_en   = !mac_load;
        mac_bias = {{(ACC_W-B1_W){b1_sel[B1_W-1]}}, b1_sel};
        mac_w    = w1_sel;
        mac_x    = x1_sel;
        if (k_q == K_W'(N_HID)) begin
          // strict compare keeps the lowest index on ties
          if (n_q == {N_W{1'b0}} || relu_s > score_q) begin
            out_d   = CLS_W'(n_q);
            score_d = relu_s;
          end else begin
            out_d   = out_q;
            score_d = score_q;
          end
          k_d = {K_W{1'b0}};
          if (n_q == N_W'(N_OUT - 1)) begin
            n_d     = {N_W{1'b0}};
            state_d = DONE;
          end else begin
            n_d = n_q + N_W'(1);
          end
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake outputs follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= {N_W{1'b0}};
      k_q         <= {K_W{1'b0}};
      inp_q       <= {(N_IN*IN_W){1'b0}};
      for (int i = 0; i < N_HID; i++) begin
        hid_q[i] <= {S_W{1'b0}};
      end
      out_q       <= {CLS_W{1'b0}};
      score_q     <= {S_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      inp_q       <= inp_d;
      hid_q       <= hid_d;
      out_q       <= out_d;
      score_q     <= score_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out       = out_q;
  assign io.out_score = score_q;
endmodule
